// File: rtl/uart_pkg.sv
// Shared UART definitions: baud select, RX/TX divisors, RX state encoding.
package uart_pkg;

  typedef logic [2:0] baud_sel_t;

  localparam int DIV_W = 9;
  // RX oversample divisors: tick period = DIV+1 clocks at 50 MHz, 16 ticks/bit
  localparam logic [DIV_W-1:0] RX_DIV_9600   = 9'd324;
  localparam logic [DIV_W-1:0] RX_DIV_19200  = 9'd162;
  localparam logic [DIV_W-1:0] RX_DIV_38400  = 9'd80;
  localparam logic [DIV_W-1:0] RX_DIV_57600  = 9'd53;
  localparam logic [DIV_W-1:0] RX_DIV_115200 = 9'd26;

  localparam int TX_DIV_W = 13;
  localparam logic [TX_DIV_W-1:0] TX_DIV_9600   = 13'd5207;
  localparam logic [TX_DIV_W-1:0] TX_DIV_19200  = 13'd2603;
  localparam logic [TX_DIV_W-1:0] TX_DIV_38400  = 13'd1301;
  localparam logic [TX_DIV_W-1:0] TX_DIV_57600  = 13'd867;
  localparam logic [TX_DIV_W-1:0] TX_DIV_115200 = 13'd433;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic [DIV_W-1:0] rx_div(input baud_sel_t sel);
    case (sel)
      3'd1:    return RX_DIV_19200;
      3'd2:    return RX_DIV_38400;
      3'd3:    return RX_DIV_57600;
      3'd4:    return RX_DIV_115200;
      default: return RX_DIV_9600;
    endcase
  endfunction

  function automatic logic [TX_DIV_W-1:0] tx_div(input baud_sel_t sel);
    case (sel)
      3'd1:    return TX_DIV_19200;
      3'd2:    return TX_DIV_38400;
      3'd3:    return TX_DIV_57600;
      3'd4:    return TX_DIV_115200;
      default: return TX_DIV_9600;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the async serial line plus falling-edge detect.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_s,
  output logic rx_fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle level so a released reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign rx_fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_byte_rx.sv
// 16x oversampled 8N1 byte receiver with 2-of-3 mid-bit vote, done/frame-error strobes.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] Baud_Set,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       Rx_Done,
  output logic       frame_err,
  output logic       uart_state
);

  logic rx_s, rx_fall;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (Clk),
    .rst    (Rst),
    .rx_in  (uart_rx),
    .rx_s   (rx_s),
    .rx_fall(rx_fall)
  );

  rx_state_t        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       samp_q, samp_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;

  logic tick, vote, bound, maj;

  assign tick  = (state_q != IDLE) && (div_cnt_q == div_q);
  assign vote  = tick && (tick_cnt_q == 4'd9);
  assign bound = tick && (tick_cnt_q == 4'd15);
  // Third vote sample is the live synchronized line on the vote tick
  assign maj   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_cnt_d  = '0;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    if (state_q != IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 9'd1;
      if (tick) tick_cnt_d = tick_cnt_q + 4'd1;
      if (tick && tick_cnt_q == 4'd7) samp_d[0] = rx_s;
      if (tick && tick_cnt_q == 4'd8) samp_d[1] = rx_s;
    end

    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d    = START;
          tick_cnt_d = '0;
          div_d      = rx_div(Baud_Set);
        end
      end
      START: begin
        if (vote && maj != START_BIT) begin
          state_d = IDLE;
        end else if (bound) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (vote) shift_d = {maj, shift_q[7:1]};
        if (bound) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed
        if (vote) begin
          state_d = IDLE;
          if (maj == STOP_BIT) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      div_q      <= RX_DIV_9600;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= '1;
      shift_q    <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_byte  = data_q;
  assign Rx_Done    = done_q;
  assign frame_err  = ferr_q;
  assign uart_state = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: serial frames driven at nominal and skewed rates.
module tb_uart_byte_rx;

  localparam int SYNC  = 2;
  localparam int P9600 = 5208;   // 50e6 / 9600 clocks per bit
  localparam int P115  = 434;    // 50e6 / 115200 clocks per bit
  localparam int VOTE_TICKS = 9 * 16 + 10;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [2:0] Baud_Set;
  logic       uart_rx;
  logic [7:0] data_byte;
  logic       Rx_Done, frame_err, uart_state;

  uart_byte_rx #(.SYNC_STAGES(SYNC)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Baud_Set  (Baud_Set),
    .uart_rx   (uart_rx),
    .data_byte (data_byte),
    .Rx_Done   (Rx_Done),
    .frame_err (frame_err),
    .uart_state(uart_state)
  );

  always #10 Clk = ~Clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, edge_cyc = 0;
  int rise_cyc = 0, fall_cyc = 0, done_cyc = 0;
  int n_err = 0, n_both = 0, n_wide = 0;
  logic st_d = 1'b0, done_d = 1'b0, st_at_done = 1'b1;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good;

  always @(posedge Clk) cyc <= cyc + 1;

  // Passive monitor: records strobes and state transitions sampled mid-cycle
  always @(negedge Clk) begin
    st_d   <= uart_state;
    done_d <= Rx_Done;
    if (uart_state && !st_d) rise_cyc <= cyc;
    if (!uart_state && st_d) fall_cyc <= cyc;
    if (Rx_Done) begin
      got_q.push_back(data_byte);
      done_cyc   <= cyc;
      st_at_done <= uart_state;
    end
    if (frame_err)            n_err  <= n_err + 1;
    if (Rx_Done && frame_err) n_both <= n_both + 1;
    if (Rx_Done && done_d)    n_wide <= n_wide + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Clocks per oversample tick for each baud select, from the rate table
  function automatic int tick_clks(input int sel);
    case (sel)
      1:       return 163;
      2:       return 81;
      3:       return 54;
      4:       return 27;
      default: return 325;
    endcase
  endfunction

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit,
                            input int stop_len);
    @(posedge Clk); #1;
    uart_rx  = 1'b0;
    edge_cyc = cyc;
    repeat (per) @(posedge Clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = b[i];
      repeat (per) @(posedge Clk);
    end
    #1 uart_rx = stop_bit;
    repeat (stop_len) @(posedge Clk);
    if (stop_bit) exp_q.push_back(b);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_done_lat(input string tag, input int sel);
    int lat, want;
    lat  = done_cyc - rise_cyc;
    want = VOTE_TICKS * tick_clks(sel) + 1;
    chk(tag, (lat >= want - 1 && lat <= want + 1) ? want : lat, want);
  endtask

  logic [7:0] lb_bytes [4] = '{8'h00, 8'hFF, 8'h55, 8'h3C};

  initial begin
    int glen, g, err_base;
    logic [7:0] rb;

    Rst = 1'b1; uart_rx = 1'b1; Baud_Set = 3'd0;
    repeat (3) @(posedge Clk); #1;
    chk("rst_data", data_byte, 8'h00);
    chk("rst_done", Rx_Done, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_state", uart_state, 1'b0);
    Rst = 1'b0;
    repeat (50) @(posedge Clk); #1;
    chk("no_false_start", uart_state, 1'b0);

    // Nominal 9600 frame; stop held only long enough to pass the mid-stop vote
    send_frame(8'hA5, P9600, 1'b1, 3400);
    repeat (20) @(posedge Clk); #1;
    chk("detect_lat", rise_cyc - edge_cyc, SYNC + 1);
    check_done_lat("done_lat_9600", 0);
    chk("state_low_at_done", st_at_done, 1'b0);
    chk("nominal_no_ferr", n_err, 0);
    check_rx("nominal");
    last_good = 8'hA5;

    // Short low glitch must be rejected as a false start
    Baud_Set = 3'd4;
    glen = $urandom_range(40, 70);
    @(posedge Clk); #1 uart_rx = 1'b0;
    repeat (glen) @(posedge Clk);
    #1 uart_rx = 1'b1;
    repeat (400) @(posedge Clk); #1;
    g = fall_cyc - rise_cyc;
    chk("glitch_recover", (g > 0 && g <= 10 * 27) ? 10 * 27 : g, 10 * 27);
    chk("glitch_state", uart_state, 1'b0);
    chk("glitch_no_ferr", n_err, 0);
    check_rx("glitch");

    // Stop bit low -> frame error, byte output untouched
    send_frame(8'h81, P115, 1'b0, P115);
    #1 uart_rx = 1'b1;
    repeat (P115) @(posedge Clk); #1;
    chk("ferr_count", n_err, 1);
    chk("ferr_data_held", data_byte, last_good);
    check_rx("ferr");

    // Recovery frame; a mid-frame Baud_Set change must not disturb it
    fork
      send_frame(8'h42, P115, 1'b1, P115);
      begin
        repeat (1500) @(posedge Clk);
        #1 Baud_Set = 3'd0;
      end
    join
    Baud_Set = 3'd4;
    repeat (20) @(posedge Clk); #1;
    check_done_lat("done_lat_115200", 4);
    chk("recover_data", data_byte, 8'h42);
    check_rx("recover");

    // Back-to-back frames as the transmitter would send them
    for (int i = 0; i < 4; i++) send_frame(lb_bytes[i], P115, 1'b1, P115);
    repeat (20) @(posedge Clk); #1;
    chk("loop_no_ferr", n_err, 1);
    check_rx("loopback");

    // +/-3% baud skew
    send_frame(8'h96, 421, 1'b1, 421);
    send_frame(8'h96, 447, 1'b1, 447);
    repeat (20) @(posedge Clk); #1;
    chk("skew_no_ferr", n_err, 1);
    check_rx("skew");

    // Reset during data bit 4; upper nibble kept high so the line stays idle afterwards
    err_base = n_err;
    rb = 8'hF0 | 8'($urandom_range(0, 15));
    @(posedge Clk); #1 uart_rx = 1'b0;
    repeat (P115) @(posedge Clk);
    for (int i = 0; i < 5; i++) begin
      #1 uart_rx = rb[i];
      repeat (i == 4 ? 200 : P115) @(posedge Clk);
    end
    #1 Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    chk("rst_mid_state", uart_state, 1'b0);
    chk("rst_mid_data", data_byte, 8'h00);
    uart_rx = 1'b1;
    repeat (2000) @(posedge Clk); #1;
    chk("rst_mid_idle", uart_state, 1'b0);
    chk("rst_mid_no_ferr", n_err, err_base);
    check_rx("rst_mid");
    send_frame(8'h5A, P115, 1'b1, P115);
    repeat (20) @(posedge Clk); #1;
    chk("post_rst_data", data_byte, 8'h5A);
    check_rx("post_rst");

    chk("done_ferr_overlap", n_both, 0);
    chk("done_pulse_width", n_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
